// File: rtl/pancham_feeder.sv
// Byte-stream front end for the pancham MD5 core: packs up to 16 bytes into msg_in,
// issues a single request, then captures the digest and the request-to-digest latency.
module pancham_feeder (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         msg_end,
    output logic         byte_ready,
    output logic [0:127] core_msg_in,
    output logic [0:7]   core_msg_in_width,
    output logic         core_msg_in_valid,
    input  logic         core_ready,
    input  logic [0:127] core_msg_output,
    input  logic         core_msg_out_valid,
    output logic [0:127] digest,
    output logic         digest_valid,
    output logic [15:0]  digest_cycles,
    output logic         err_ovf
);

    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT_DIG, REPORT} state_t;

    state_t        state_reg, state_next;
    logic [127:0]  msg_reg, msg_next, msg_fill;
    logic [4:0]    count_reg, count_next;
    logic          ovf_reg, ovf_next;
    logic          byte_ready_reg, byte_ready_next;
    logic          req_reg, req_next;
    logic [127:0]  digest_reg, digest_next;
    logic          digest_valid_reg, digest_valid_next;
    logic [15:0]   cycles_reg, cycles_next;
    logic [15:0]   cyc_cnt_reg, cyc_cnt_next, cyc_inc;
    logic          err_ovf_reg, err_ovf_next;
    logic          clear_buf;

    logic accept_byte, accept_end, store_byte, ovf_hit;

    // byte_ready_reg is only ever high in COLLECT, so it doubles as the accept qualifier
    assign accept_byte = byte_ready_reg && byte_valid;
    assign accept_end  = byte_ready_reg && msg_end;
    assign store_byte  = accept_byte && !count_reg[4];
    assign ovf_hit     = ovf_reg || (accept_byte && count_reg[4]);
    assign cyc_inc     = (cyc_cnt_reg == 16'hFFFF) ? 16'hFFFF : cyc_cnt_reg + 16'd1;

    // Byte k lands in lane k, counted from the least-significant end
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign msg_fill[8*gi +: 8] = (store_byte && count_reg[3:0] == 4'(gi))
                                         ? byte_in : msg_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        ovf_next          = ovf_reg;
        clear_buf         = 1'b0;
        req_next          = 1'b0;
        err_ovf_next      = 1'b0;
        digest_valid_next = 1'b0;
        digest_next       = digest_reg;
        cycles_next       = cycles_reg;
        cyc_cnt_next      = cyc_cnt_reg;

        case (state_reg)
            COLLECT: begin
                if (store_byte)
                    count_next = count_reg + 5'd1;
                if (accept_byte && count_reg[4])
                    ovf_next = 1'b1;
                if (accept_end) begin
                    if (ovf_hit) begin
                        err_ovf_next = 1'b1;
                        clear_buf    = 1'b1;
                        count_next   = 5'd0;
                        ovf_next     = 1'b0;
                    end else begin
                        state_next = ISSUE;
                        req_next   = core_ready;
                    end
                end
            end
            ISSUE: begin
                // The request pulse is registered from the core_ready sampled one edge earlier
                if (req_reg) begin
                    state_next   = WAIT_DIG;
                    cyc_cnt_next = 16'd0;
                end else begin
                    req_next = core_ready;
                end
            end
            WAIT_DIG: begin
                cyc_cnt_next = cyc_inc;
                if (core_msg_out_valid) begin
                    digest_next       = core_msg_output;
                    cycles_next       = cyc_inc;
                    digest_valid_next = 1'b1;
                    state_next        = REPORT;
                end
            end
            REPORT: begin
                clear_buf  = 1'b1;
                count_next = 5'd0;
                state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase

        msg_next        = clear_buf ? 128'd0 : msg_fill;
        byte_ready_next = (state_next == COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= COLLECT;
            msg_reg          <= 128'd0;
            count_reg        <= 5'd0;
            ovf_reg          <= 1'b0;
            byte_ready_reg   <= 1'b0;
            req_reg          <= 1'b0;
            digest_reg       <= 128'd0;
            digest_valid_reg <= 1'b0;
            cycles_reg       <= 16'd0;
            cyc_cnt_reg      <= 16'd0;
            err_ovf_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            msg_reg          <= msg_next;
            count_reg        <= count_next;
            ovf_reg          <= ovf_next;
            byte_ready_reg   <= byte_ready_next;
            req_reg          <= req_next;
            digest_reg       <= digest_next;
            digest_valid_reg <= digest_valid_next;
            cycles_reg       <= cycles_next;
            cyc_cnt_reg      <= cyc_cnt_next;
            err_ovf_reg      <= err_ovf_next;
        end
    end

    assign byte_ready        = byte_ready_reg;
    assign core_msg_in       = msg_reg;
    assign core_msg_in_width = {count_reg, 3'b000};
    assign core_msg_in_valid = req_reg;
    assign digest            = digest_reg;
    assign digest_valid      = digest_valid_reg;
    assign digest_cycles     = cycles_reg;
    assign err_ovf           = err_ovf_reg;

endmodule

// File: doc/pancham_feeder.md
# pancham_feeder

Host-side driver for the pancham MD5 core: accepts a message as a byte stream, packs up to 16 bytes into the core's 128-bit `msg_in` word (first byte in the least-significant byte lane), issues one request when the core is ready, captures the returned digest and reports it with an issue-to-digest cycle count. It sits between a byte-oriented host (UART/bus bridge) and `pancham`, taking over the stimulus role on the core's `msg_in`/`msg_output` interface.

## Interface
- No parameters; 16-byte (128-bit) message limit is fixed by the core.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `byte_in`  in  8  message byte.
- `byte_valid`  in  1  `byte_in` valid; accepted when `byte_ready` is high.
- `msg_end`  in  1  end of message; may coincide with `byte_valid` (byte included) or arrive alone (zero bytes gives an empty message).
- `byte_ready`  out  1  block is in COLLECT.
- `core_msg_in`  out  [0:127]  to `pancham.msg_in`.
- `core_msg_in_width`  out  [0:7]  to `pancham.msg_in_width`, message length in bits.
- `core_msg_in_valid`  out  1  to `pancham.msg_in_valid`, one-cycle request pulse.
- `core_ready`  in  1  from `pancham.ready`.
- `core_msg_output`  in  [0:127]  from `pancham.msg_output`.
- `core_msg_out_valid`  in  1  from `pancham.msg_out_valid`.
- `digest`  out  [0:127]  captured digest, held until the next capture.
- `digest_valid`  out  1  one-cycle pulse when `digest` updates.
- `digest_cycles`  out  16  cycles from request pulse to digest capture, saturating at 16'hFFFF, held with `digest`.
- `err_ovf`  out  1  one-cycle pulse: message exceeded 16 bytes and was discarded.

## Operation
- States: COLLECT, ISSUE, WAIT_DIG, REPORT.
- COLLECT: `byte_ready`=1. Each accepted byte k (0-based, k<16) is written to `core_msg_in[120-8k : 127-8k]`. The byte counter increments, and the width is 8*count. Unfilled lanes stay zero.
- Byte with count=16: dropped, sticky `ovf` flag set.
- `msg_end` accepted in COLLECT:
  - If `ovf` is set (including an overflow byte in the same cycle): pulse `err_ovf`, clear the buffer, counter and `ovf`, and stay in COLLECT.
  - Otherwise go to ISSUE.
- ISSUE: `byte_ready`=0. The first cycle `core_ready`=1 drives `core_msg_in_valid`=1 for exactly that cycle, clears the cycle counter and moves to WAIT_DIG. `core_msg_in`/`core_msg_in_width` are stable from ISSUE entry through that pulse.
- WAIT_DIG: the cycle counter increments each cycle, saturating. On `core_msg_out_valid`=1, capture `core_msg_output` into `digest` and the counter into `digest_cycles`, then go to REPORT.
- REPORT: `digest_valid`=1 for one cycle. Clear the buffer, count and width, then return to COLLECT.
- `byte_valid`/`msg_end` outside COLLECT are ignored, since the host must honour `byte_ready`.
- Asynchronous reset at any point, including WAIT_DIG, returns to COLLECT with the buffer cleared. An in-flight core result is not captured; the core shares `reset`.

## Timing
- All outputs are registered. Reset values: `byte_ready`=0, `core_msg_in`=0, `core_msg_in_width`=0, `core_msg_in_valid`=0, `digest`=0, `digest_valid`=0, `digest_cycles`=0, `err_ovf`=0.
- `byte_ready` rises on the first clock edge after reset deasserts. It falls on the edge that accepts `msg_end` (no overflow).
- `msg_end` accepted at edge N, with `core_ready` high: `core_msg_in_valid` high in cycle N+1.
- `core_msg_out_valid` sampled at edge M: `digest_valid` high in cycle M+1, and `byte_ready` high again in cycle M+2.
- `digest_cycles` = number of edges from the request-pulse edge to the capture edge, minimum 1.
- `err_ovf` is high in the cycle after `msg_end`; `byte_ready` stays high.

## Test plan
- Send "abc" with `msg_end` on 'c' -> `core_msg_in`=128'h636261 (right-aligned), width=8'h18, single request pulse, `digest`=128'h900150983cd24fb0d6963f7d28e17f72, one `digest_valid` pulse.
- Send `msg_end` alone -> width=8'h00, `core_msg_in`=0, `digest`=128'hd41d8cd98f00b204e9800998ecf8427e.
- Send "message digest" (14 bytes) -> width=8'h70, `digest`=128'hf96b697d7cb7938d525a2f31aaf161d0, `digest_cycles` equals the measured pulse-to-`core_msg_out_valid` distance.
- Send 17 bytes of 'x' then `msg_end` -> `err_ovf` one pulse, no `core_msg_in_valid`; a following "a" message gives `digest`=128'h0cc175b9c0f1b6a831c399e269772661.
- Hold `core_ready` low for 20 cycles after `msg_end` -> `core_msg_in_valid` stays 0 with operands stable, then exactly one pulse on the first ready cycle.
- Assert `reset` during WAIT_DIG -> all outputs at reset values, no `digest_valid`; a subsequent "abc" message completes correctly.
